// File: rtl/parity_frame_tx_if.sv
// ============================================================================
// Module      : parity_frame_tx_if
// Description : Bundle for the parity frame transmitter: the parallel
//               valid/ready word input and the serial frame output.
//               With PARITY_FLIP_EN defined, it also carries inject_err, a
//               per-frame parity-inversion request sampled at accept.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface parity_frame_tx_if #(
    parameter int DATA_W = 8
) ();

    // Word input handshake
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
`ifdef PARITY_FLIP_EN
    logic              inject_err;
`endif

    // Serial frame output
    logic              ser_out;
    logic              ser_valid;
    logic              frame_start;
    logic              frame_end;
    logic [1:0]        run_state;

    // Word source and frame observer
    modport master (
        output in_valid,
        output in_data,
`ifdef PARITY_FLIP_EN
        output inject_err,
`endif
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  frame_start,
        input  frame_end,
        input  run_state
    );

    // Transmitter
    modport slave (
        input  in_valid,
        input  in_data,
`ifdef PARITY_FLIP_EN
        input  inject_err,
`endif
        output in_ready,
        output ser_out,
        output ser_valid,
        output frame_start,
        output frame_end,
        output run_state
    );

endinterface

`default_nettype wire

// File: rtl/parity_frame_tx.sv
// ============================================================================
// Module      : parity_frame_tx
// Description : Serial frame transmitter. Accepts a DATA_W-bit word on a
//               valid/ready handshake, shifts it out MSB-first, appends a
//               parity bit so the frame's count of 1s has the parity chosen
//               by ODD_ONES, then idles GAP_CYCLES cycles. run_state tracks
//               {odd zeros, odd ones} over the frame bits already emitted.
//               Optional macro PARITY_FLIP_EN adds inject_err, which inverts
//               the parity bit of the frame it is accepted with.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module parity_frame_tx #(
    parameter int   DATA_W     = 8,
    parameter int   ODD_ONES   = 0,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    parity_frame_tx_if.slave   bus
);

    // Counter wide enough for both the payload index (<= 31) and gap (<= 15)
    localparam int                CNT_W      = 6;
    localparam logic [CNT_W-1:0]  C_LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  C_LAST_GAP = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic              C_ODD_ONES = 1'(ODD_ONES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t             r_state;
    logic [DATA_W-2:0]  r_shift;       // payload bits still to be emitted, next one at MSB
    logic [CNT_W-1:0]   r_cnt;
    logic               r_parity;
    logic               r_ser_out;
    logic               r_ser_valid;
    logic               r_frame_start;
    logic               r_frame_end;
    logic [1:0]         r_run_state;

    logic               w_inject;
    logic               w_word_parity;

`ifdef PARITY_FLIP_EN
    assign w_inject = bus.inject_err;
`else
    assign w_inject = 1'b0;
`endif

    assign w_word_parity = ^bus.in_data;

    // Ready comes from registered state only; forced low while reset is held
    assign bus.in_ready    = (r_state == S_IDLE) && !reset;
    assign bus.ser_out     = r_ser_out;
    assign bus.ser_valid   = r_ser_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_end   = r_frame_end;
    assign bus.run_state   = r_run_state;

    // Frame sequencer: accept, shift payload, emit parity, idle gap; tracks run parity
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_parity      <= 1'b0;
            r_ser_out     <= IDLE_LEVEL;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_run_state   <= 2'b00;
        end else begin
            // Fold the bit shown this cycle into the running parity
            if (r_ser_valid) begin
                if (r_ser_out) begin
                    r_run_state[0] <= ~r_run_state[0];
                end else begin
                    r_run_state[1] <= ~r_run_state[1];
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        // MSB goes straight to the output; the rest waits in the shifter
                        r_shift       <= bus.in_data[DATA_W-2:0];
                        r_parity      <= w_word_parity ^ C_ODD_ONES ^ w_inject;
                        r_cnt         <= '0;
                        r_ser_out     <= bus.in_data[DATA_W-1];
                        r_ser_valid   <= 1'b1;
                        r_frame_start <= 1'b1;
                        r_run_state   <= 2'b00;
                        r_state       <= S_DATA;
                    end
                end

                S_DATA: begin
                    r_frame_start <= 1'b0;
                    if (r_cnt == C_LAST_BIT) begin
                        r_ser_out   <= r_parity;
                        r_frame_end <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_PARITY;
                    end else begin
                        r_ser_out <= r_shift[DATA_W-2];
                        r_shift   <= r_shift << 1;
                        r_cnt     <= r_cnt + CNT_W'(1);
                    end
                end

                S_PARITY: begin
                    r_frame_end <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_ser_out   <= IDLE_LEVEL;
                    r_cnt       <= '0;
                    r_state     <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end

                S_GAP: begin
                    if (r_cnt == C_LAST_GAP) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
- Serial frame transmitter for the zeros/ones parity-tracking stream.
- Accepts a parallel word on a valid/ready handshake and shifts it out MSB-first, one bit per clk.
- Appends one parity bit so the frame's count of 1s has the configured parity.
- Exports the running {zeros-parity, ones-parity} state of the emitted frame, using the same 2-bit encoding as the stream checker, so the two can be cross-compared.

Parameters:
- DATA_W, 8: payload width in bits, 2..32.
- ODD_ONES, 0: 0 = total 1s in frame (payload + parity) even; 1 = odd.
- GAP_CYCLES, 2: idle cycles after the parity bit before in_ready reasserts, 0..15.
- IDLE_LEVEL, 1'b1: ser_out value whenever ser_valid = 0.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  DATA_W  payload word
- ser_out  output  1  serial bit
- ser_valid  output  1  ser_out carries a frame bit
- frame_start  output  1  pulse on the first payload bit
- frame_end  output  1  pulse on the parity bit
- run_state  output  2  [1] = odd count of 0s, [0] = odd count of 1s, over frame bits emitted in prior cycles

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk.
- Reset values: state IDLE, ser_valid 0, ser_out IDLE_LEVEL, frame_start 0, frame_end 0, run_state 2'b00, shift register and counters 0. in_ready is 0 while reset is asserted.
- States and transitions:
  - IDLE: in_ready = 1. On in_valid & in_ready, load in_data, clear run_state to 00, go to DATA.
  - DATA: lasts DATA_W cycles; ser_out = shift MSB; ser_valid = 1; frame_start = 1 in the first DATA cycle only. Then go to PARITY.
  - PARITY: 1 cycle; ser_out = parity bit; ser_valid = 1; frame_end = 1. Then go to GAP, or to IDLE if GAP_CYCLES = 0.
  - GAP: GAP_CYCLES cycles with ser_valid 0, then IDLE.
- Latency: first payload bit appears on the cycle after acceptance. Frame is DATA_W+1 bits.
- Throughput: with in_valid held high, consecutive frame_start pulses are DATA_W+GAP_CYCLES+3 cycles apart. The one IDLE cycle per frame is intentional.
- in_ready depends only on registered state; no combinational path from in_valid.
- in_data is ignored outside the accept cycle; later changes have no effect on the frame in flight.
- Parity bit = XOR(payload) XOR ODD_ONES.
- run_state update: registered; each emitted frame bit b toggles bit[0] if b = 1, else bit[1]. It holds the final frame value through GAP/IDLE until the next accept clears it.
- Final run_state for a correct frame: {((DATA_W+1-ones) mod 2), ODD_ONES}, where ones = count of 1s in the whole frame including the parity bit.
- Reset mid-frame: frame abandoned immediately; no frame_end; outputs at reset values. First cycle after deassertion is IDLE with in_ready = 1.
- in_valid low in IDLE: remain in IDLE, outputs static.

Optional Feature:
- Macro: PARITY_FLIP_EN.
- Defined:
  - Adds input port inject_err (1 bit), sampled only on the accept cycle.
  - If sampled 1, that frame's parity bit is inverted and run_state reflects the inverted bit.
  - Used to drive error cases into the checker.
- Undefined: no inject_err port; parity bit always per ODD_ONES.

Test Plan (DATA_W=8, GAP_CYCLES=2, IDLE_LEVEL=1 unless stated):
1. ODD_ONES=0, in_data=8'hA5 -> ser_out 1,0,1,0,0,1,0,1 then parity 0; frame_end on the 9th bit; final run_state 2'b10.
2. ODD_ONES=0, in_data=8'h07 -> parity 1; run_state 2'b10. Rebuild with ODD_ONES=1, same data -> parity 0; run_state 2'b01.
3. in_valid held high, words 8'hFF then 8'h00, accept at cycle 0 -> second frame_start at cycle 13; parity bits 0 and 0; in_ready low cycles 1..11.
4. reset asserted during the 4th payload bit of 8'hA5 -> ser_valid 0 and ser_out 1 immediately; no frame_end; run_state 00; in_ready 1 the first cycle after release.
5. in_valid 0 for 20 cycles after reset -> ser_valid 0, ser_out 1, in_ready 1, run_state 00 throughout.
6. PARITY_FLIP_EN defined, ODD_ONES=0, in_data=8'hA5, inject_err=1 at accept -> parity bit 1; final run_state 2'b01.
